// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 double-buffered frame store.
// Pixel layout is {R,G,B}, with R in the top channel.
package hub75_pkg;

  localparam int unsigned BPP = 8;
  localparam int unsigned R_IDX = 2;
  localparam int unsigned G_IDX = 1;
  localparam int unsigned B_IDX = 0;

  typedef logic [2:0][BPP-1:0] pixel_t;

  typedef enum logic {
    SW_IDLE,
    SW_PEND
  } swap_state_e;

endpackage

// File: rtl/hub75_fb_bank.sv
// One frame bank: a single write port and one registered read port
// per scan segment. Read registers hold their value while re_i is low.
module hub75_fb_bank
  import hub75_pkg::*;
#(
  parameter int unsigned depth_p          = 64,
  parameter int unsigned segments_p       = 2,
  parameter int unsigned seg_size_p       = 32,
  parameter int unsigned bpp_p            = 8,
  parameter int unsigned addr_width_p     = 6,
  parameter int unsigned seg_addr_width_p = 5
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 we_i,
  input  logic [addr_width_p-1:0]              waddr_i,
  input  logic [2:0][bpp_p-1:0]                wdata_i,
  input  logic                                 re_i,
  input  logic [seg_addr_width_p-1:0]          raddr_i,
  output logic [segments_p-1:0][2:0][bpp_p-1:0] rdata_o
);

  logic [2:0][bpp_p-1:0] mem_q [depth_p];
  logic [segments_p-1:0][2:0][bpp_p-1:0] rdata_q;
  logic [segments_p-1:0][2:0][bpp_p-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Segment s sees the same row offset, one segment further down.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      for (int s = 0; s < int'(segments_p); s++) begin
        rdata_d[s] = mem_q[addr_width_p'(int'(raddr_i) + s * int'(seg_size_p))];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/hub75_frame_buffer.sv
// Double-buffered HUB75 frame store: writers fill the back bank,
// a commit is swapped in at the next scan-driver frame boundary.
module hub75_frame_buffer
  import hub75_pkg::*;
#(
  parameter int unsigned hpixel_p   = 8,
  parameter int unsigned vpixel_p   = 8,
  parameter int unsigned bpp_p      = 8,
  parameter int unsigned segments_p = 2,
  localparam int unsigned frame_size_p     = hpixel_p * vpixel_p,
  localparam int unsigned seg_size_p       = frame_size_p / segments_p,
  localparam int unsigned addr_width_p     = $clog2(frame_size_p),
  localparam int unsigned seg_addr_width_p = $clog2(seg_size_p)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_wr_valid,
  output logic                                  o_wr_ready,
  input  logic [addr_width_p-1:0]               i_wr_addr,
  input  logic [2:0][bpp_p-1:0]                 i_wr_data,
  input  logic                                  i_wr_commit,
  output logic                                  o_wr_err,
  input  logic                                  i_frame_sync,
  input  logic                                  i_rd_en,
  input  logic [seg_addr_width_p-1:0]           i_rd_addr,
  output logic [segments_p-1:0][2:0][bpp_p-1:0] o_rd_data,
  output logic                                  o_rd_valid,
  output logic                                  o_active_bank,
  output logic                                  o_swap_pending
);

  if (vpixel_p % segments_p != 0) begin : g_bad_segments
    $error("vpixel_p must be a multiple of segments_p");
  end

  swap_state_e state_q, state_d;
  logic active_q, active_d;
  logic err_q, err_d;
  logic rd_valid_q;
  logic rd_sel_q;
  logic wr_acc;
  logic in_range;
  logic [1:0] bank_we;
  logic [1:0] bank_re;
  logic [segments_p-1:0][2:0][bpp_p-1:0] bank_rdata [2];

  assign o_wr_ready = (state_q == SW_IDLE);
  assign wr_acc     = i_wr_valid && o_wr_ready;
  assign in_range   = 32'(i_wr_addr) < frame_size_p;
  assign err_d      = wr_acc && !in_range;

  for (genvar k = 0; k < 2; k++) begin : g_bank
    assign bank_we[k] = wr_acc && in_range && (active_q != 1'(k));
    assign bank_re[k] = i_rd_en && (active_q == 1'(k));

    hub75_fb_bank #(
      .depth_p          (frame_size_p),
      .segments_p       (segments_p),
      .seg_size_p       (seg_size_p),
      .bpp_p            (bpp_p),
      .addr_width_p     (addr_width_p),
      .seg_addr_width_p (seg_addr_width_p)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (bank_we[k]),
      .waddr_i (i_wr_addr),
      .wdata_i (i_wr_data),
      .re_i    (bank_re[k]),
      .raddr_i (i_rd_addr),
      .rdata_o (bank_rdata[k])
    );
  end

  // A commit landing on a sync edge swaps immediately, never pending.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    unique case (state_q)
      SW_IDLE: begin
        if (i_wr_commit) begin
          if (i_frame_sync) begin
            active_d = ~active_q;
          end else begin
            state_d = SW_PEND;
          end
        end
      end
      SW_PEND: begin
        if (i_frame_sync) begin
          active_d = ~active_q;
          state_d  = SW_IDLE;
        end
      end
      default: state_d = SW_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SW_IDLE;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      err_q      <= err_d;
      rd_valid_q <= i_rd_en;
      if (i_rd_en) begin
        rd_sel_q <= active_q;
      end
    end
  end

  // Output follows the bank that served the last read, so it holds.
  assign o_rd_data      = rd_sel_q ? bank_rdata[1] : bank_rdata[0];
  assign o_rd_valid     = rd_valid_q;
  assign o_wr_err       = err_q;
  assign o_active_bank  = active_q;
  assign o_swap_pending = (state_q == SW_PEND);

endmodule
